// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Optional taint tracking is enabled with the MULT_ARB_TAINT_EN macro.
package mult_arb_pkg;

    localparam int unsigned DefaultWidth = 1024;
    localparam int unsigned DefaultNreq  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Index width for n requesters; never below 1 bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ = DefaultNreq,
    localparam int unsigned IDW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any_req
);

    logic [IDW-1:0] cand;
    logic           found;

    // Scan from ptr upward modulo NREQ and keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((ptr + k) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = found;
        any_req          = found;
    end

endmodule

// File: rtl/mult_share_arbiter_taint.sv
// Shares one sequential multiplier among NREQ requesters with round-robin
// arbitration and returns each product to its owner over valid/ready.
// Define MULT_ARB_TAINT_EN to propagate 1-bit taint; otherwise taints are 0.
module mult_share_arbiter_taint
    import mult_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned NREQ  = DefaultNreq,
    localparam int unsigned IDW  = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_valid_t,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_op_t,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic                  resp_valid_t,
    output logic [2*WIDTH-1:0]    resp_product,
    output logic                  resp_product_t,
    input  logic [NREQ-1:0]       resp_ready,
    output logic                  mult_start,
    output logic                  mult_start_t,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    output logic                  mult_op_t,
    input  logic                  mult_done,
    input  logic                  mult_done_t,
    input  logic [2*WIDTH-1:0]    mult_product,
    input  logic                  mult_product_t,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id
);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] win_idx;
    logic [NREQ-1:0] win_gnt;
    logic           any_req;
    logic           accept;
    logic           capture;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (win_gnt),
        .grant_idx (win_idx),
        .any_req   (any_req)
    );

    assign accept  = (state_q == IDLE) && any_req;
    assign capture = (state_q == WAIT) && mult_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (mult_done) state_d = RESP;
            RESP:    if (resp_ready[grant_id]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        req_ready  = accept ? win_gnt : '0;
        resp_valid = '0;
        if (state_q == RESP) resp_valid[grant_id] = 1'b1;
        mult_start = (state_q == ISSUE);
        busy       = (state_q != IDLE);
    end

    // Grant bookkeeping and operand capture on the accept handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            grant_id <= '0;
            mult_a   <= '0;
            mult_b   <= '0;
        end else if (accept) begin
            rr_ptr_q <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
            grant_id <= win_idx;
            mult_a   <= req_a[win_idx*WIDTH +: WIDTH];
            mult_b   <= req_b[win_idx*WIDTH +: WIDTH];
        end
    end

    // Product capture; done pulses outside WAIT are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         resp_product <= '0;
        else if (capture) resp_product <= mult_product;
    end

`ifdef MULT_ARB_TAINT_EN
    logic arb_t_q;
    logic op_t_q;
    logic resp_vt_q;
    logic prod_t_q;

    // Taints latch at grant / product capture and hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arb_t_q   <= 1'b0;
            op_t_q    <= 1'b0;
            resp_vt_q <= 1'b0;
            prod_t_q  <= 1'b0;
        end else begin
            if (accept) begin
                // The winner depends on every valid, so any tainted valid taints the decision.
                arb_t_q <= |req_valid_t;
                op_t_q  <= req_op_t[win_idx] | (|req_valid_t);
            end
            if (capture) begin
                resp_vt_q <= arb_t_q | mult_done_t;
                prod_t_q  <= mult_product_t | op_t_q | arb_t_q;
            end
        end
    end

    assign mult_start_t   = arb_t_q;
    assign mult_op_t      = op_t_q;
    assign resp_valid_t   = resp_vt_q;
    assign resp_product_t = prod_t_q;
`else
    logic unused_taint;
    assign unused_taint   = ^{req_valid_t, req_op_t, mult_done_t, mult_product_t};
    assign mult_start_t   = 1'b0;
    assign mult_op_t      = 1'b0;
    assign resp_valid_t   = 1'b0;
    assign resp_product_t = 1'b0;
`endif

endmodule
